// File: rtl/mem_byte_seq_arb_if.sv
// Bus bundle between fetch/LSU requesters, the byte sequencer and the byte-wide RAM.
// Slave modport is the sequencer's view; master is the requester/memory side.
interface mem_byte_seq_arb_if #(
    parameter int ADR_W = 14
);
    logic             i_req;
    logic [ADR_W-1:0] i_adr;
    logic             i_ack;
    logic [31:0]      i_dat;

    logic             d_req;
    logic             d_we;
    logic [1:0]       d_size;
    logic [ADR_W-1:0] d_adr;
    logic [31:0]      d_wdat;
    logic             d_ack;
    logic [31:0]      d_rdat;
    logic             d_err;

    logic [ADR_W-1:0] mem_adr;
    logic [7:0]       mem_dat_o;
    logic [7:0]       mem_dat_i;
    logic             mem_we;
    logic             mem_en;

    modport slave (
        input  i_req, i_adr,
        output i_ack, i_dat,
        input  d_req, d_we, d_size, d_adr, d_wdat,
        output d_ack, d_rdat, d_err,
        output mem_adr, mem_dat_o, mem_we, mem_en,
        input  mem_dat_i
    );

    modport master (
        output i_req, i_adr,
        input  i_ack, i_dat,
        output d_req, d_we, d_size, d_adr, d_wdat,
        input  d_ack, d_rdat, d_err,
        input  mem_adr, mem_dat_o, mem_we, mem_en,
        output mem_dat_i
    );
endinterface

// File: rtl/mem_byte_seq_arb.sv
// Round-robin fetch/data arbiter that sequences accesses as big-endian byte cycles.
// Define MEMSEQ_ALIGN_CHK_EN to reject misaligned data half/word accesses with d_err.
module mem_byte_seq_arb #(
    parameter int ADR_W = 14
) (
    input logic              clk,
    input logic              rst,
    mem_byte_seq_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    state_t state, state_nx;
    port_t  last_grant, port_q;

    logic [ADR_W-1:0] base_q;
    logic [1:0]       last_q;
    logic [1:0]       k_q;
    logic             we_q;
    logic [31:0]      wdat_q;
    logic [23:0]      shift_q;
    logic             err_q;
    logic [31:0]      i_dat_q;
    logic [31:0]      d_rdat_q;

    logic        grant_any;
    logic        grant_d;
    logic        mis;
    logic [1:0]  sel;
    logic [7:0]  wbyte;
    logic [31:0] shift_nx;

    logic             i_ack_c;
    logic             d_ack_c;
    logic             d_err_c;
    logic             mem_en_c;
    logic             mem_we_c;
    logic [ADR_W-1:0] mem_adr_c;
    logic [7:0]       mem_dat_c;

    function automatic logic [1:0] size_last(input logic [1:0] sz);
        logic [1:0] r;
        unique case (sz)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Both requesting: the port that did not win last time gets the grant.
    always_comb begin
        grant_any = bus.i_req | bus.d_req;
        grant_d   = bus.d_req & (~bus.i_req | (last_grant == PORT_I));
    end

`ifdef MEMSEQ_ALIGN_CHK_EN
    always_comb begin
        mis = 1'b0;
        unique case (1'b1)
            bus.d_size == 2'b00: mis = 1'b0;
            bus.d_size == 2'b01: mis = bus.d_adr[0];
            default:             mis = bus.d_adr[1:0] != 2'b00;
        endcase
        mis = mis & grant_d;
    end
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        sel      = last_q - k_q;
        wbyte    = wdat_q[{sel, 3'b000} +: 8];
        shift_nx = {shift_q, bus.mem_dat_i};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nx = mis ? DONE : XFER;
                end
            end
            XFER: begin
                if (k_q == last_q) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are gated by rst so an abort stops the memory cycle in progress.
    always_comb begin
        i_ack_c   = 1'b0;
        d_ack_c   = 1'b0;
        d_err_c   = 1'b0;
        mem_en_c  = 1'b0;
        mem_we_c  = 1'b0;
        mem_adr_c = '0;
        mem_dat_c = '0;
        if (rst) begin
            unique case (state)
                XFER: begin
                    mem_en_c  = 1'b1;
                    mem_we_c  = we_q;
                    mem_adr_c = base_q + ADR_W'(k_q);
                    mem_dat_c = we_q ? wbyte : 8'h00;
                end
                DONE: begin
                    i_ack_c = port_q == PORT_I;
                    d_ack_c = port_q == PORT_D;
                    d_err_c = (port_q == PORT_D) & err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= PORT_I;
            port_q     <= PORT_I;
            base_q     <= '0;
            last_q     <= '0;
            k_q        <= '0;
            we_q       <= 1'b0;
            wdat_q     <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
            i_dat_q    <= '0;
            d_rdat_q   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        port_q     <= grant_d ? PORT_D : PORT_I;
                        last_grant <= grant_d ? PORT_D : PORT_I;
                        base_q     <= grant_d ? bus.d_adr : bus.i_adr;
                        last_q     <= grant_d ? size_last(bus.d_size) : 2'd3;
                        we_q       <= grant_d & bus.d_we;
                        wdat_q     <= grant_d ? bus.d_wdat : 32'h0;
                        k_q        <= '0;
                        shift_q    <= '0;
                        err_q      <= mis;
                    end
                end
                XFER: begin
                    k_q     <= k_q + 2'd1;
                    shift_q <= shift_nx[23:0];
                    if (k_q == last_q && !we_q) begin
                        if (port_q == PORT_I) begin
                            i_dat_q <= shift_nx;
                        end else begin
                            d_rdat_q <= shift_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.i_ack     = i_ack_c;
    assign bus.i_dat     = i_dat_q;
    assign bus.d_ack     = d_ack_c;
    assign bus.d_rdat    = d_rdat_q;
    assign bus.d_err     = d_err_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_adr   = mem_adr_c;
    assign bus.mem_dat_o = mem_dat_c;
endmodule

// File: tb/tb_mem_byte_seq_arb.sv
// Bench for mem_byte_seq_arb: request-level model plus directed vectors.
// Build with or without MEMSEQ_ALIGN_CHK_EN.
`timescale 1ns/1ps
module tb_mem_byte_seq_arb;
    localparam int ADR_W = 14;
    localparam int MSZ   = 1 << ADR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_byte_seq_arb_if #(.ADR_W(ADR_W)) bus();
    mem_byte_seq_arb #(.ADR_W(ADR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pre(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    // Byte-wide RAM with combinational read
    logic [7:0] tb_mem [MSZ];
    bit mem_loaded;
    assign bus.mem_dat_i = tb_mem[bus.mem_adr];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < MSZ; a++) tb_mem[a] <= pre(a);
            mem_loaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            tb_mem[bus.mem_adr] <= bus.mem_dat_o;
        end
    end

    // Request-level model: timeline of one access counted from its grant
    logic [7:0]       ref_mem [MSZ];
    bit               ref_loaded;
    bit               m_busy, m_last_d, m_d, m_we, m_err;
    int               m_len, m_nmem, m_cyc;
    logic [ADR_W-1:0] m_base;
    logic [31:0]      m_wdat, m_rd;
    logic [31:0]      exp_idat = '0;
    logic [31:0]      exp_drdat = '0;

    task automatic publish();
        if (!m_we && !m_err) begin
            if (m_d) exp_drdat = m_rd;
            else     exp_idat  = m_rd;
        end
    endtask

    always @(posedge clk) begin
        if (!ref_loaded) begin
            for (int a = 0; a < MSZ; a++) ref_mem[a] = pre(a);
            ref_loaded = 1'b1;
        end
        if (!rst) begin
            m_busy = 0; m_last_d = 0; exp_idat = '0; exp_drdat = '0;
        end else if (m_busy) begin
            if (m_cyc == m_nmem + 1) begin
                m_busy = 0;
            end else begin
                if (m_we)
                    ref_mem[(int'(m_base) + m_cyc - 1) % MSZ] =
                        8'((m_wdat >> (8 * (m_len - m_cyc))) & 32'hFF);
                m_cyc++;
                if (m_cyc == m_nmem + 1) publish();
            end
        end else if (bus.i_req || bus.d_req) begin
            m_d      = bus.d_req && (!bus.i_req || !m_last_d);
            m_last_d = m_d;
            m_base   = m_d ? bus.d_adr : bus.i_adr;
            m_len    = !m_d ? 4 : (bus.d_size == 2'b00 ? 1 : (bus.d_size == 2'b01 ? 2 : 4));
            m_we     = m_d && bus.d_we;
            m_wdat   = bus.d_wdat;
            m_err    = 0;
`ifdef MEMSEQ_ALIGN_CHK_EN
            if (m_d && m_len > 1 && (int'(m_base) % m_len) != 0) m_err = 1;
`endif
            m_rd = '0;
            for (int j = 0; j < m_len; j++)
                m_rd = (m_rd << 8) | 32'(ref_mem[(int'(m_base) + j) % MSZ]);
            m_nmem = m_err ? 0 : m_len;
            m_cyc  = 1;
            m_busy = 1;
            if (m_err) publish();
        end
    end

    // Per-cycle comparison against the model
    always begin : cmp
        logic             e_en, e_we, e_ack;
        logic [ADR_W-1:0] e_adr;
        logic [7:0]       e_do;
        @(negedge clk);
        #1;
        e_en  = rst && m_busy && (m_cyc <= m_nmem);
        e_we  = e_en && m_we;
        e_adr = e_en ? ADR_W'(int'(m_base) + m_cyc - 1) : '0;
        e_do  = e_we ? 8'((m_wdat >> (8 * (m_len - m_cyc))) & 32'hFF) : 8'h00;
        e_ack = rst && m_busy && (m_cyc == m_nmem + 1);
        chk("mem_en", 32'(bus.mem_en), 32'(e_en));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_adr", 32'(bus.mem_adr), 32'(e_adr));
        chk("mem_dat_o", 32'(bus.mem_dat_o), 32'(e_do));
        chk("i_ack", 32'(bus.i_ack), 32'(e_ack && !m_d));
        chk("d_ack", 32'(bus.d_ack), 32'(e_ack && m_d));
        chk("d_err", 32'(bus.d_err), 32'(e_ack && m_d && m_err));
        chk("i_dat", bus.i_dat, exp_idat);
        chk("d_rdat", bus.d_rdat, exp_drdat);
    end

    logic [ADR_W-1:0] adr_q [$];

    task automatic xfer(input bit is_d, input bit we, input logic [1:0] sz,
                        input logic [ADR_W-1:0] adr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output bit err);
        lat = -1; rd = '0; err = 0;
        adr_q.delete();
        @(negedge clk);
        if (is_d) begin
            bus.d_we = we; bus.d_size = sz; bus.d_adr = adr; bus.d_wdat = wd;
            bus.d_req = 1'b1;
        end else begin
            bus.i_adr = adr; bus.i_req = 1'b1;
        end
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.mem_en) adr_q.push_back(bus.mem_adr);
            if (is_d ? bus.d_ack : bus.i_ack) begin
                lat = c;
                rd  = is_d ? bus.d_rdat : bus.i_dat;
                err = bus.d_err;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin : stim
        int          lat, acks, diffs, t_first, t_second;
        logic [31:0] rd;
        bit          err;
        bit          order [$];

        bus.i_req = 1'b1; bus.i_adr = 14'h0080;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10;
        bus.d_adr = 14'h0040; bus.d_wdat = '0;
        rst = 1'b0;

        // Reset with both requests pending
        repeat (2) @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_acks", {30'h0, bus.i_ack, bus.d_ack}, 32'h0);
        chk("rst_i_dat", bus.i_dat, 32'h0);
        rst = 1'b1;

        // Contention: both held, grants alternate starting with data
        t_first = -1; t_second = -1;
        for (int c = 1; c <= 100 && order.size() < 4; c++) begin
            @(negedge clk);
            if (bus.d_ack) order.push_back(1'b1);
            if (bus.i_ack) order.push_back(1'b0);
            if ((bus.d_ack || bus.i_ack) && t_first < 0) t_first = c;
            else if ((bus.d_ack || bus.i_ack) && t_second < 0) t_second = c;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("rr_count", order.size(), 4);
        chk("rr_order", (order.size() == 4) ? {28'h0, order[0], order[1], order[2], order[3]} : 32'hFFFF,
            32'b1010);
        chk("rr_first_lat", t_first, 5);
        chk("rr_second_lat", t_second, 11);
        chk("rr_d_rdat", bus.d_rdat, 32'hC3CAD1D8);
        chk("rr_i_dat", bus.i_dat, 32'h838A9198);

        // Word write then fetch
        xfer(1, 1, 2'b10, 14'h0010, 32'hDEADBEEF, lat, rd, err);
        chk("ww_lat", lat, 5);
        chk("ww_adr_seq", {adr_q.size() == 4 ? 8'(adr_q[0]) : 8'hFF, 8'(adr_q.size())}, 16'h1004);
        @(negedge clk);
        chk("ww_bytes", {tb_mem[16], tb_mem[17], tb_mem[18], tb_mem[19]}, 32'hDEADBEEF);
        xfer(0, 0, 2'b10, 14'h0010, 32'h0, lat, rd, err);
        chk("if_lat", lat, 5);
        chk("if_dat", rd, 32'hDEADBEEF);

        // Byte write, half read
        xfer(1, 1, 2'b00, 14'h0021, 32'h1234565A, lat, rd, err);
        chk("bw_lat", lat, 2);
        xfer(1, 0, 2'b01, 14'h0020, 32'h0, lat, rd, err);
        chk("hr_lat", lat, 3);
        chk("hr_dat", rd, 32'h0000E35A);

`ifdef MEMSEQ_ALIGN_CHK_EN
        // Misaligned half write is rejected without touching memory
        xfer(1, 1, 2'b01, 14'h0001, 32'h0000BEEF, lat, rd, err);
        chk("al_lat", lat, 1);
        chk("al_err", 32'(err), 32'h1);
        chk("al_no_mem", adr_q.size(), 0);
        chk("al_mem1", 32'(tb_mem[1]), 32'h0A);
        xfer(1, 0, 2'b11, 14'h3FFE, 32'h0, lat, rd, err);
        chk("al_w_err", 32'(err), 32'h1);
`else
        // Misaligned word read wraps the address space
        xfer(1, 0, 2'b10, 14'h3FFE, 32'h0, lat, rd, err);
        chk("wr_lat", lat, 5);
        chk("wr_dat", rd, 32'hF5FC030A);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_adr_seq", (adr_q.size() == 4) ?
            {8'(adr_q[0] >> 6), 8'(adr_q[1]), 8'(adr_q[2]), 8'(adr_q[3])} : 32'hFFFF_FFFF,
            32'hFFFF_0001);
`endif

        // Reset during the third byte cycle of a word write
        @(negedge clk);
        @(negedge clk);
        bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_adr = 14'h0100;
        bus.d_wdat = 32'hA1B2C3D4; bus.d_req = 1'b1;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.d_ack) acks++;
        end
        rst = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        if (bus.d_ack) acks++;
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.d_ack || bus.mem_en) acks++;
        end
        chk("ab_no_ack", acks, 0);
        chk("ab_bytes", {tb_mem[256], tb_mem[257], tb_mem[258], tb_mem[259]}, 32'hA1B2_1118);
        xfer(1, 0, 2'b00, 14'h0101, 32'h0, lat, rd, err);
        chk("ab_after_lat", lat, 2);
        chk("ab_after_dat", rd, 32'h000000B2);

        repeat (3) @(negedge clk);
        diffs = 0;
        for (int a = 0; a < MSZ; a++) if (tb_mem[a] !== ref_mem[a]) diffs++;
        chk("mem_image", diffs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_byte_seq_arb.md
Name: mem_byte_seq_arb

Overview:
- Two-port arbiter and sequencer in front of the 16 KiB byte-wide on-chip memory (14-bit address, 8-bit data, en/we, combinational read).
- Ports: an instruction-fetch port (word reads only) and a data port (byte, half and word reads/writes).
- Splits each 32-bit-class access into consecutive big-endian byte cycles and returns one ack per request.
- Sits between the CPU's fetch/LSU and the memory instance inside mem_if.

Parameters:
ADR_W, 14, memory byte-address width; address arithmetic wraps modulo 2^ADR_W

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous reset, active-low: sampled low at a clk edge resets the block
i_req  in  1  instruction fetch request, held until i_ack
i_adr  in  ADR_W  fetch byte address
i_ack  out  1  one-cycle pulse: fetch complete, i_dat valid this cycle
i_dat  out  32  fetched word, big-endian
d_req  in  1  data request, held with d_we/d_size/d_adr/d_wdat until d_ack
d_we  in  1  1 = write, 0 = read
d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
d_adr  in  ADR_W  data byte address
d_wdat  in  32  write data, right-justified (byte = [7:0], half = [15:0])
d_ack  out  1  one-cycle pulse: data access complete
d_rdat  out  32  read data, zero-extended, right-justified; valid when d_ack=1
d_err  out  1  alignment error, valid with d_ack (see Optional Feature)
mem_adr  out  ADR_W  memory byte address
mem_dat_o  out  8  write byte to memory
mem_dat_i  in  8  read byte from memory (combinational)
mem_we  out  1  memory write enable
mem_en  out  1  memory enable

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - All outputs 0: i_ack, d_ack, d_err, mem_en, mem_we, mem_adr, mem_dat_o, i_dat, d_rdat.
  - last_grant=INSTR, so data wins the first tie.
- Reset mid-transfer aborts immediately. No ack is issued; any partial write stays in memory.
- States: IDLE, XFER, DONE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the port not in last_grant (round-robin). Update last_grant.
  - Latch port, address, size n (1/2/4 bytes), we and write data. Clear byte counter k=0. Go to XFER.
  - No req: stay in IDLE with mem_en=0.
- XFER, one byte per cycle:
  - mem_en=1, mem_we=latched we, mem_adr=(base+k) mod 2^ADR_W.
  - Write: mem_dat_o = byte (n-1-k) of write data, i.e. MSB first, big-endian.
  - Read: mem_dat_i is captured at the edge into the result shift register, MSB first.
  - After k=n-1, go to DONE.
- DONE:
  - mem_en=0. Pulse the granted port's ack for exactly one cycle; rdata/i_dat are valid with it.
  - Go to IDLE.
- Latency: ack asserted n+1 cycles after the IDLE edge that granted the request. Word = 5 cycles, half = 3, byte = 2.
- The earliest next grant is the cycle after DONE. One idle cycle minimum between accesses.
- mem_dat_o=0 and mem_we=0 whenever not in an XFER write cycle. mem_we is never high while mem_en is low.
- i_dat and d_rdat hold their last value until the next completion of the same port.
- A requester dropping req mid-transfer is a protocol violation. The controller still completes and acks.
- A requester keeping req high in the ack cycle is treated as a new request at the next IDLE.
- d_err=0 always when the optional feature is compiled out.

Optional Feature:
- Macro: MEMSEQ_ALIGN_CHK_EN.
- Defined:
  - Granted data access is misaligned if half has adr[0]=1, or word has adr[1:0]!=0.
  - Misaligned: go IDLE->DONE with no memory cycle (mem_en stays 0). d_ack=1, d_err=1, d_rdat unchanged.
  - Fetch misalignment is ignored.
- Undefined: no check, d_err tied 0. Misaligned accesses proceed byte-wise with address wrap.

Test Plan:
- Reset: rst=0 for 2 cycles with i_req=d_req=1 -> all outputs 0, no mem_en; after rst=1 the first grant goes to data.
- Word write then fetch: d_req, we=1, size=10, adr=0x0010, wdat=0xDEADBEEF -> bytes DE,AD,BE,EF at 0x10..0x13, d_ack at cycle 5. Then i_req adr=0x0010 -> i_dat=0xDEADBEEF with i_ack at cycle 5.
- Sub-word: byte write 0x5A at 0x0021, half read at 0x0020 -> d_rdat=0x0000xx5A (xx = preloaded 0x20), ack 3 cycles after grant.
- Contention: i_req and d_req held high continuously -> grants alternate D,I,D,I; each ack is a single-cycle pulse; no port starves.
- Wrap: word read at 0x3FFE (no align check) -> mem_adr sequence 3FFE,3FFF,0000,0001.
- Abort: rst=0 during the third XFER cycle of a word write -> only the first two bytes written, no d_ack, state IDLE; with MEMSEQ_ALIGN_CHK_EN, a half write at 0x0001 -> d_ack=d_err=1 one cycle after grant, mem_en never high.
